// File: rtl/mr_wb_arb_pkg.sv
// ----------------------------------------------------------------------------
// mr_wb_arb_pkg
//   Shared definitions for the writeback scheduler and the decode tag
//   generator:
//     XLEN / REGSEL  - data width and register-select width
//     WB_SEQ_BITS    - default width of the issue sequence tag
//     t_wb_req       - one buffered writeback {rd, val, seq, jmp}
//     seq_older()    - wrap-safe "a was issued before b" compare
// ----------------------------------------------------------------------------
package mr_wb_arb_pkg;

    localparam int XLEN        = 32;
    localparam int REGSEL      = 5;
    localparam int WB_SEQ_BITS = 4;

    typedef logic [WB_SEQ_BITS-1:0] t_seq;

    // One pending register-file write. rd = 0 means "no architectural write"
    // (stores, pure branches) but the entry still occupies a writeback slot.
    typedef struct packed {
        logic [REGSEL-1:0] rd;
        logic [XLEN-1:0]   val;
        t_seq              seq;
        logic              jmp;
    } t_wb_req;

    // a is older than b when (a - b) mod 2**WB_SEQ_BITS has its MSB set.
    // Correct as long as fewer than 2**(WB_SEQ_BITS-1) results are in flight.
    function automatic logic seq_older(input t_seq a, input t_seq b);
        t_seq diff;
        diff = a - b;
        return diff[WB_SEQ_BITS-1];
    endfunction

endpackage

// File: rtl/mr_wb_fifo.sv
// ----------------------------------------------------------------------------
// mr_wb_fifo
//   DEPTH-entry FIFO of t_wb_req with a combinational head view, used to
//   buffer one result producer in front of the writeback arbiter.
//   Ports:
//     clk, rst   - clock, asynchronous active-high reset (pointers only)
//     push, din  - write an entry (ignored while full)
//     pop        - drop the head entry (ignored while empty)
//     full/empty - occupancy flags
//     head       - current oldest entry, valid when !empty
// ----------------------------------------------------------------------------
module mr_wb_fifo
    import mr_wb_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  t_wb_req din,
    input  logic    pop,
    output logic    full,
    output logic    empty,
    output t_wb_req head
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty.
    logic [AW:0] wr_ptr_reg;
    logic [AW:0] rd_ptr_reg;
    t_wb_req     mem_reg [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    // A full FIFO refuses the push even when the head leaves this cycle.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem_reg[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/mr_wb_arb.sv
// ----------------------------------------------------------------------------
// mr_wb_arb
//   Writeback scheduler: shares the single register-file write port and the
//   jmp_done strobe between the ALU/branch path and the load/store unit.
//   Each producer feeds a DEPTH-entry FIFO; the older of the two heads (by
//   issue sequence tag, wrap-safe) is written back, one entry per cycle, so
//   writes to the same register retire in program order.
//   Optional feature macro: MR_WB_PERF_EN adds conflict_cnt, a 32-bit count
//   of cycles in which both FIFO heads were valid.
//   Ports:
//     clk, rst                 - clock, asynchronous active-high reset
//     alu_wb_valid/ready       - ALU handshake
//     alu_wb_reg/val/seq/jmp   - ALU result, tag and branch-resolve flag
//     mem_wb_valid/ready       - load/store handshake
//     mem_wb_reg/val/seq       - LSU result and tag (reg 0 for stores)
//     wb_valid/wb_reg/wb_val   - registered register-file write to decode
//     jmp_done                 - registered one-cycle branch-resolved pulse
//     conflict_cnt             - only with MR_WB_PERF_EN
// ----------------------------------------------------------------------------
module mr_wb_arb
    import mr_wb_arb_pkg::*;
#(
    parameter int DEPTH    = 2,
    // Must match WB_SEQ_BITS: the buffered tag width comes from the package.
    parameter int SEQ_BITS = WB_SEQ_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alu_wb_valid,
    output logic                alu_wb_ready,
    input  logic [REGSEL-1:0]   alu_wb_reg,
    input  logic [XLEN-1:0]     alu_wb_val,
    input  logic [SEQ_BITS-1:0] alu_wb_seq,
    input  logic                alu_wb_jmp,
    input  logic                mem_wb_valid,
    output logic                mem_wb_ready,
    input  logic [REGSEL-1:0]   mem_wb_reg,
    input  logic [XLEN-1:0]     mem_wb_val,
    input  logic [SEQ_BITS-1:0] mem_wb_seq,
    output logic                wb_valid,
    output logic [REGSEL-1:0]   wb_reg,
    output logic [XLEN-1:0]     wb_val,
    output logic                jmp_done
`ifdef MR_WB_PERF_EN
    ,
    output logic [31:0]         conflict_cnt
`endif
);

    localparam int JC_W = $clog2(DEPTH + 1);

    t_wb_req   alu_din;
    t_wb_req   mem_din;
    t_wb_req   alu_head;
    t_wb_req   mem_head;
    logic      alu_full;
    logic      alu_empty;
    logic      mem_full;
    logic      mem_empty;
    logic      alu_push;
    logic      mem_push;
    logic      alu_hv;
    logic      mem_hv;
    logic      grant_alu;
    logic      grant_mem;
    logic [JC_W-1:0] jmp_cnt_reg;

    // ------------------------------------------------------------------
    // Accept side
    // ------------------------------------------------------------------
    assign alu_wb_ready = ~alu_full & ~rst;
    assign mem_wb_ready = ~mem_full & ~rst;
    assign alu_push     = alu_wb_valid & alu_wb_ready;
    assign mem_push     = mem_wb_valid & mem_wb_ready;

    assign alu_din = '{rd: alu_wb_reg, val: alu_wb_val,
                       seq: t_seq'(alu_wb_seq), jmp: alu_wb_jmp};
    // The LSU never resolves branches.
    assign mem_din = '{rd: mem_wb_reg, val: mem_wb_val,
                       seq: t_seq'(mem_wb_seq), jmp: 1'b0};

    mr_wb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (alu_push),
        .din   (alu_din),
        .pop   (grant_alu),
        .full  (alu_full),
        .empty (alu_empty),
        .head  (alu_head)
    );

    mr_wb_fifo #(.DEPTH(DEPTH)) u_mem_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (mem_push),
        .din   (mem_din),
        .pop   (grant_mem),
        .full  (mem_full),
        .empty (mem_empty),
        .head  (mem_head)
    );

    // ------------------------------------------------------------------
    // Grant: oldest head first. Equal tags cannot legally occur; if they
    // do, the MEM head wins because seq_older(x, x) is 0.
    // ------------------------------------------------------------------
    assign alu_hv    = ~alu_empty;
    assign mem_hv    = ~mem_empty;
    assign grant_mem = mem_hv & (~alu_hv | ~seq_older(alu_head.seq, mem_head.seq));
    assign grant_alu = alu_hv & ~grant_mem;

    // ------------------------------------------------------------------
    // Registered writeback port
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid <= 1'b0;
            wb_reg   <= '0;
            wb_val   <= '0;
            jmp_done <= 1'b0;
        end else begin
            wb_valid <= grant_alu | grant_mem;
            // mem_head.jmp is tied low at the FIFO input.
            jmp_done <= (grant_alu & alu_head.jmp) | (grant_mem & mem_head.jmp);
            if (grant_mem) begin
                wb_reg <= mem_head.rd;
                wb_val <= mem_head.val;
            end else if (grant_alu) begin
                wb_reg <= alu_head.rd;
                wb_val <= alu_head.val;
            end
        end
    end

    // Number of jmp entries currently buffered in the ALU FIFO; decode only
    // ever has one branch outstanding, so this must stay at 0 or 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            jmp_cnt_reg <= '0;
        end else begin
            case ({alu_push & alu_wb_jmp, grant_alu & alu_head.jmp})
                2'b10:   jmp_cnt_reg <= jmp_cnt_reg + JC_W'(1);
                2'b01:   jmp_cnt_reg <= jmp_cnt_reg - JC_W'(1);
                default: jmp_cnt_reg <= jmp_cnt_reg;
            endcase
        end
    end

`ifdef MR_WB_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if (alu_hv & mem_hv) begin
            conflict_cnt <= conflict_cnt + 32'd1;
        end
    end
`endif

    a_unique_tags: assert property (@(posedge clk) disable iff (rst)
        !(alu_hv && mem_hv && (alu_head.seq == mem_head.seq)))
        else $error("mr_wb_arb: both heads carry the same sequence tag");

    a_single_jmp: assert property (@(posedge clk) disable iff (rst)
        jmp_cnt_reg <= JC_W'(1))
        else $error("mr_wb_arb: more than one jmp entry buffered");

endmodule

// File: tb/tb_mr_wb_arb.sv
`timescale 1ns/1ps
module tb_mr_wb_arb;
    import mr_wb_arb_pkg::*;

    localparam int DEPTH = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              alu_wb_valid, alu_wb_ready, alu_wb_jmp;
    logic [REGSEL-1:0] alu_wb_reg;
    logic [XLEN-1:0]   alu_wb_val;
    logic [3:0]        alu_wb_seq;
    logic              mem_wb_valid, mem_wb_ready;
    logic [REGSEL-1:0] mem_wb_reg;
    logic [XLEN-1:0]   mem_wb_val;
    logic [3:0]        mem_wb_seq;
    logic              wb_valid, jmp_done;
    logic [REGSEL-1:0] wb_reg;
    logic [XLEN-1:0]   wb_val;
`ifdef MR_WB_PERF_EN
    logic [31:0]       conflict_cnt;
    logic [31:0]       cc0;
`endif

    mr_wb_arb #(.DEPTH(DEPTH), .SEQ_BITS(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .alu_wb_valid (alu_wb_valid),
        .alu_wb_ready (alu_wb_ready),
        .alu_wb_reg   (alu_wb_reg),
        .alu_wb_val   (alu_wb_val),
        .alu_wb_seq   (alu_wb_seq),
        .alu_wb_jmp   (alu_wb_jmp),
        .mem_wb_valid (mem_wb_valid),
        .mem_wb_ready (mem_wb_ready),
        .mem_wb_reg   (mem_wb_reg),
        .mem_wb_val   (mem_wb_val),
        .mem_wb_seq   (mem_wb_seq),
        .wb_valid     (wb_valid),
        .wb_reg       (wb_reg),
        .wb_val       (wb_val),
        .jmp_done     (jmp_done)
`ifdef MR_WB_PERF_EN
        ,
        .conflict_cnt (conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Model: each producer is a queue of entries tagged with an unbounded
    // issue number (program order); the 4-bit tag is just iss mod 16.
    typedef struct {
        int          iss;
        logic [4:0]  rd;
        logic [31:0] val;
        logic        jmp;
    } ent_t;

    ent_t        aq[$];
    ent_t        mq[$];
    int          alu_iss = 0, mem_iss = 0;
    int          n_tests = 0, n_fail = 0;
    int          n_acc = 0, n_ret = 0, n_disc = 0;
    logic [31:0] rf [32];
    int          next_iss = 40;
    bit          ap = 0, mp = 0, a_acc, m_acc, done;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Compare process: checks outputs every cycle at the falling edge and
    // advances the model across the following rising edge.
    // ------------------------------------------------------------------
    initial begin : compare
        logic        ev, ej;
        logic [4:0]  er;
        logic [31:0] evl;
        bit          g_alu, g_mem, a_ok, m_ok;
        ent_t        e;
        ev = 0; ej = 0; er = 0; evl = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_wb_valid", wb_valid, 0);
                chk("rst_jmp_done", jmp_done, 0);
                chk("rst_wb_reg", wb_reg, 0);
                chk("rst_wb_val", wb_val, 0);
                chk("rst_alu_ready", alu_wb_ready, 0);
                chk("rst_mem_ready", mem_wb_ready, 0);
                n_disc += aq.size() + mq.size() + (ev ? 1 : 0);
                aq.delete();
                mq.delete();
                ev = 0;
                ej = 0;
            end else begin
                chk("wb_valid", wb_valid, ev);
                chk("jmp_done", jmp_done, ej);
                if (ev) begin
                    chk("wb_reg", wb_reg, er);
                    chk("wb_val", wb_val, evl);
                end
                if (wb_valid) begin
                    n_ret++;
                    rf[wb_reg] = wb_val;
                end
                a_ok = aq.size() < DEPTH;
                m_ok = mq.size() < DEPTH;
                chk("alu_ready", alu_wb_ready, a_ok);
                chk("mem_ready", mem_wb_ready, m_ok);
                // Oldest in program order wins; one writeback per cycle.
                g_alu = (aq.size() > 0) && ((mq.size() == 0) || (aq[0].iss < mq[0].iss));
                g_mem = (mq.size() > 0) && !g_alu;
                ev = g_alu || g_mem;
                ej = 0;
                if (g_alu) begin
                    e = aq.pop_front();
                    er = e.rd; evl = e.val; ej = e.jmp;
                end else if (g_mem) begin
                    e = mq.pop_front();
                    er = e.rd; evl = e.val;
                end
                if (alu_wb_valid && a_ok) begin
                    aq.push_back('{iss: alu_iss, rd: alu_wb_reg, val: alu_wb_val, jmp: alu_wb_jmp});
                    n_acc++;
                end
                if (mem_wb_valid && m_ok) begin
                    mq.push_back('{iss: mem_iss, rd: mem_wb_reg, val: mem_wb_val, jmp: 1'b0});
                    n_acc++;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        alu_wb_valid = 0;
        alu_wb_jmp   = 0;
        mem_wb_valid = 0;
    endtask

    task automatic set_alu(input int iss, input logic [4:0] rd, input logic [31:0] val, input logic jmp);
        alu_wb_valid = 1; alu_iss = iss; alu_wb_seq = 4'(iss);
        alu_wb_reg = rd; alu_wb_val = val; alu_wb_jmp = jmp;
    endtask

    task automatic set_mem(input int iss, input logic [4:0] rd, input logic [31:0] val);
        mem_wb_valid = 1; mem_iss = iss; mem_wb_seq = 4'(iss);
        mem_wb_reg = rd; mem_wb_val = val;
    endtask

    task automatic drain(input int n);
        idle();
        repeat (n) tick();
    endtask

    // Keep every live tag within 6 issue slots of the newest one.
    function automatic bit window_ok();
        int oldest = next_iss;
        foreach (aq[i]) if (aq[i].iss < oldest) oldest = aq[i].iss;
        foreach (mq[i]) if (mq[i].iss < oldest) oldest = mq[i].iss;
        if (ap && alu_iss < oldest) oldest = alu_iss;
        if (mp && mem_iss < oldest) oldest = mem_iss;
        return (next_iss - oldest) < 6;
    endfunction

    function automatic bit jmp_ok();
        foreach (aq[i]) if (aq[i].jmp) return 0;
        return 1;
    endfunction

    // ------------------------------------------------------------------
    // Directed scenarios, then randomized traffic
    // ------------------------------------------------------------------
    initial begin : driver
        idle();
        alu_wb_reg = 0; alu_wb_val = 0; alu_wb_seq = 0;
        mem_wb_reg = 0; mem_wb_val = 0; mem_wb_seq = 0;
        foreach (rf[i]) rf[i] = 0;
        rst = 1;
        repeat (2) tick();
        chk("reset_alu_ready", alu_wb_ready, 0);
        chk("reset_wb_valid", wb_valid, 0);
        rst = 0;
        tick();

        // 1: single ALU result, visible two edges after being offered
        set_alu(0, 5, 32'h1234, 0);
        tick();
        idle();
        chk("t1_not_yet", wb_valid, 0);
        tick();
        chk("t1_valid", wb_valid, 1);
        chk("t1_reg", wb_reg, 5);
        chk("t1_val", wb_val, 32'h1234);
        tick();
        chk("t1_one_cycle", wb_valid, 0);
        drain(2);

        // 2: same register from both producers, MEM is older
`ifdef MR_WB_PERF_EN
        cc0 = conflict_cnt;
`endif
        set_alu(2, 3, 32'hAAAA, 0);
        set_mem(1, 3, 32'hBBBB);
        tick();
        idle();
        tick();
        chk("t2_first_val", wb_val, 32'hBBBB);
        tick();
        chk("t2_second_valid", wb_valid, 1);
        chk("t2_second_val", wb_val, 32'hAAAA);
        tick();
        chk("t2_r3_final", rf[3], 32'hAAAA);
`ifdef MR_WB_PERF_EN
        chk("t2_conflict_cnt", conflict_cnt, cc0 + 32'd1);
`endif
        drain(2);

        // 3: tag wrap, ALU seq 15 is older than MEM seq 0
        set_alu(15, 7, 32'h0F0F, 0);
        set_mem(16, 8, 32'h1010);
        tick();
        idle();
        tick();
        chk("t3_first_reg", wb_reg, 7);
        chk("t3_first_val", wb_val, 32'h0F0F);
        tick();
        chk("t3_second_reg", wb_reg, 8);
        drain(2);

        // 4: MEM fills while older ALU entries keep winning
        set_alu(4, 4, 32'h44, 0);
        tick();
        set_alu(5, 5, 32'h55, 0);
        set_mem(6, 6, 32'h66);
        tick();
        set_alu(8, 8, 32'h88, 0);
        set_mem(7, 7, 32'h77);
        chk("t4_mem_ready_2nd", mem_wb_ready, 1);
        tick();
        alu_wb_valid = 0;
        set_mem(9, 9, 32'h99);
        chk("t4_mem_full", mem_wb_ready, 0);
        tick();
        chk("t4_mem_ready_again", mem_wb_ready, 1);
        tick();
        drain(5);

        // 5: branch resolve pulse aligned with its writeback
        set_alu(20, 1, 32'h55AA, 1);
        tick();
        idle();
        chk("t5_jmp_early", jmp_done, 0);
        tick();
        chk("t5_valid", wb_valid, 1);
        chk("t5_jmp", jmp_done, 1);
        chk("t5_reg", wb_reg, 1);
        tick();
        chk("t5_jmp_once", jmp_done, 0);
        drain(2);

        // 6: reset with two entries buffered
        set_alu(30, 10, 32'hA0, 0);
        tick();
        set_alu(31, 11, 32'hA1, 0);
        set_mem(32, 12, 32'hA2);
        tick();
        idle();
        chk("t6_pre_valid", wb_valid, 1);
        rst = 1;
        #1;
        chk("t6_rst_valid", wb_valid, 0);
        chk("t6_rst_val", wb_val, 0);
        chk("t6_rst_ready", alu_wb_ready, 0);
        tick();
        tick();
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_no_wb_after_rst", wb_valid, 0);
        end
`ifdef MR_WB_PERF_EN
        chk("t6_conflict_cnt", conflict_cnt, 0);
`endif

        // Random traffic with one mid-run reset
        for (int c = 0; c < 600; c++) begin
            if (c == 300) rst = 1;
            if (c == 302) rst = 0;
            if (!ap && $urandom_range(0, 2) != 0 && window_ok()) begin
                set_alu(next_iss, 5'($urandom_range(0, 7)), $urandom,
                        jmp_ok() && ($urandom_range(0, 3) == 0));
                next_iss++;
                ap = 1;
            end
            if (!mp && $urandom_range(0, 2) != 0 && window_ok()) begin
                set_mem(next_iss, 5'($urandom_range(0, 7)), $urandom);
                next_iss++;
                mp = 1;
            end
            a_acc = alu_wb_valid && !rst && (aq.size() < DEPTH);
            m_acc = mem_wb_valid && !rst && (mq.size() < DEPTH);
            tick();
            if (a_acc) begin ap = 0; alu_wb_valid = 0; alu_wb_jmp = 0; end
            if (m_acc) begin mp = 0; mem_wb_valid = 0; end
        end

        // Drain outstanding offers and buffered entries
        done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            a_acc = alu_wb_valid && (aq.size() < DEPTH);
            m_acc = mem_wb_valid && (mq.size() < DEPTH);
            tick();
            if (a_acc) begin ap = 0; alu_wb_valid = 0; alu_wb_jmp = 0; end
            if (m_acc) begin mp = 0; mem_wb_valid = 0; end
            done = !ap && !mp && (aq.size() == 0) && (mq.size() == 0);
        end
        chk("drain_done", done, 1);
        drain(3);
        chk("scoreboard_balance", n_ret + n_disc, n_acc);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
